// File: rtl/rca4s.sv
// Ripple-carry adder/subtractor with combinational result and a registered copy.
// Optional overflow outputs are enabled by defining RCA4S_OVERFLOW_EN.
module rca4s #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Subtract,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] SumQ,
    output logic             CoutQ
`ifdef RCA4S_OVERFLOW_EN
    ,
    output logic             Overflow,
    output logic             OverflowQ
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] bx;

    // Subtraction is A + ~B + 1: invert B per bit and inject the 1 as carry-in.
    assign c[0] = Subtract;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign bx[i]    = B[i] ^ Subtract;
        assign Sum[i]   = A[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (A[i] & bx[i]) | (A[i] & c[i]) | (bx[i] & c[i]);
    end

    assign Cout = c[WIDTH];

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    assign sum_d  = Sum;
    assign cout_d = Cout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign SumQ  = sum_q;
    assign CoutQ = cout_q;

`ifdef RCA4S_OVERFLOW_EN
    logic ovf_d, ovf_q;

    assign ovf_d    = c[WIDTH] ^ c[WIDTH-1];
    assign Overflow = ovf_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign OverflowQ = ovf_q;
`endif

endmodule

// File: tb/tb_rca4s.sv
// Self-checking bench for rca4s at WIDTH=4: directed vectors, register/reset
// sequences and an exhaustive sweep against an arithmetic reference model.
module tb_rca4s;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] A, B;
    logic       Subtract;
    logic [3:0] Sum, SumQ;
    logic       Cout, CoutQ;
`ifdef RCA4S_OVERFLOW_EN
    logic       Overflow, OverflowQ;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rca4s #(.WIDTH(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .Subtract (Subtract),
        .Sum      (Sum),
        .Cout     (Cout),
        .SumQ     (SumQ),
        .CoutQ    (CoutQ)
`ifdef RCA4S_OVERFLOW_EN
        ,
        .Overflow (Overflow),
        .OverflowQ(OverflowQ)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{4'b0100, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0};
        vecs[1] = '{4'b0100, 4'b0001, 1'b1, 4'b0011, 1'b1, 1'b0};
        vecs[2] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[4] = '{4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0};
        vecs[5] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};

        // Reset asserted from time zero: registered outputs must be 0.
        Reset = 1'b1; A = 4'd5; B = 4'd6; Subtract = 1'b0;
        #1;
        check("reset_sumq", 32'(SumQ), 32'd0);
        check("reset_coutq", 32'(CoutQ), 32'd0);
        check("reset_comb_sum", 32'(Sum), 32'd11);
        @(posedge Clk); #1;
        check("reset_hold_sumq", 32'(SumQ), 32'd0);
`ifdef RCA4S_OVERFLOW_EN
        check("reset_ovfq", 32'(OverflowQ), 32'd0);
`endif
        @(negedge Clk);
        Reset = 1'b0;

        // Directed combinational vectors.
        for (int i = 0; i < 6; i++) begin
            A = vecs[i].a; B = vecs[i].b; Subtract = vecs[i].sub;
            #1;
            check($sformatf("vec%0d_sum", i), 32'(Sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(Cout), 32'(vecs[i].cout));
`ifdef RCA4S_OVERFLOW_EN
            check($sformatf("vec%0d_ovf", i), 32'(Overflow), 32'(vecs[i].ovf));
`endif
        end

        // Registered path: zero-latency Sum, one-edge latency SumQ.
        @(negedge Clk);
        A = 4'b0011; B = 4'b0010; Subtract = 1'b0;
        #1;
        check("reg_comb_sum", 32'(Sum), 32'd5);
        @(posedge Clk); #1;
        check("reg_sumq", 32'(SumQ), 32'd5);
        check("reg_coutq", 32'(CoutQ), 32'd0);
        A = 4'b1111; B = 4'b0001;
        #1;
        check("reg_sumq_holds", 32'(SumQ), 32'd5);
        check("reg_comb_new", 32'(Sum), 32'd0);
        @(posedge Clk); #1;
        check("reg_sumq_wrap", 32'(SumQ), 32'd0);
        check("reg_coutq_set", 32'(CoutQ), 32'd1);

        // Overflowing add captured, then async reset mid-cycle.
        @(negedge Clk);
        A = 4'b0111; B = 4'b0001;
        @(posedge Clk); #1;
        check("pre_rst_sumq", 32'(SumQ), 32'd8);
`ifdef RCA4S_OVERFLOW_EN
        check("pre_rst_ovfq", 32'(OverflowQ), 32'd1);
`endif
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("async_rst_sumq", 32'(SumQ), 32'd0);
        check("async_rst_coutq", 32'(CoutQ), 32'd0);
        check("async_rst_comb_sum", 32'(Sum), 32'd8);
`ifdef RCA4S_OVERFLOW_EN
        check("async_rst_ovfq", 32'(OverflowQ), 32'd0);
        check("async_rst_comb_ovf", 32'(Overflow), 32'd1);
`endif
        #2;
        Reset = 1'b0;
        #1;
        check("post_rst_before_edge", 32'(SumQ), 32'd0);
        @(posedge Clk); #1;
        check("post_rst_reload", 32'(SumQ), 32'd8);
`ifdef RCA4S_OVERFLOW_EN
        check("post_rst_ovfq", 32'(OverflowQ), 32'd1);
`endif

        // Exhaustive sweep against an arithmetic reference.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    int bx, tot;
                    logic [3:0] es;
                    logic       ec;
                    bx  = (s != 0) ? (~b & 15) : b;
                    tot = a + bx + s;
                    es  = 4'(tot & 15);
                    ec  = ((tot >> 4) & 1) != 0;
                    A = 4'(a); B = 4'(b); Subtract = (s != 0);
                    #1;
                    check($sformatf("exh_sum a=%0d b=%0d s=%0d", a, b, s), 32'(Sum), 32'(es));
                    check($sformatf("exh_cout a=%0d b=%0d s=%0d", a, b, s), 32'(Cout), 32'(ec));
`ifdef RCA4S_OVERFLOW_EN
                    begin
                        logic eo;
                        eo = (A[3] == 1'(bx >> 3)) && (es[3] != A[3]);
                        check($sformatf("exh_ovf a=%0d b=%0d s=%0d", a, b, s), 32'(Overflow), 32'(eo));
                    end
`endif
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
